// File: rtl/v_tile.sv
`default_nettype none
// ============================================================================
//  Module   : v_tile
//  Brief    : CGRA vector reduction tile. Buffers two operand vectors and a
//             config word through four-phase write ports. When enabled, emits
//             pairwise sums of adjacent elements with a destination tag and a
//             one-cycle completion strobe.
//  Options  : ADDER_SAT_EN - saturate each pairwise sum on unsigned overflow
//             instead of wrapping modulo 2^WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module v_tile #(
    parameter int WIDTH      = 16,
    parameter int NUM_INPUTS = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                on_off,
    // Operand A
    input  logic                                write_en1,
    output logic                                write_rdy1,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0]    w_data_in1,
    output logic                                write_ack1,
    // Operand B
    input  logic                                write_en2,
    output logic                                write_rdy2,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0]    w_data_in2,
    output logic                                write_ack2,
    // Config word
    input  logic                                write_en3,
    output logic                                write_rdy3,
    input  logic [WIDTH-1:0]                    w_data_in3,
    output logic                                write_ack3,
    // Results
    output logic [NUM_INPUTS-1:0][WIDTH-1:0]    adder_outputs,
    output logic [$clog2(NUM_REGS)-1:0]         dest_info,
    output logic                                adder_ack
);

    localparam int c_HALF   = NUM_INPUTS / 2;
    localparam int c_DEST_W = $clog2(NUM_REGS);

    // Buffered operands and configuration
    logic [NUM_INPUTS-1:0][WIDTH-1:0] r_a_data;
    logic [NUM_INPUTS-1:0][WIDTH-1:0] r_b_data;
    logic [WIDTH-1:0]                 r_cfg;
    logic                             r_a_full;
    logic                             r_b_full;
    logic                             r_cfg_valid;

    // Handshake acknowledges
    logic                             r_ack1;
    logic                             r_ack2;
    logic                             r_ack3;

    // Registered results
    logic [NUM_INPUTS-1:0][WIDTH-1:0] r_out;
    logic [c_DEST_W-1:0]              r_dest;
    logic                             r_done;

    // Combinational control
    logic                             w_cap1;
    logic                             w_cap2;
    logic                             w_cap3;
    logic                             w_fire;
    logic [NUM_INPUTS-1:0][WIDTH-1:0] w_sum;
    logic                             w_unused_cfg;

    // Pairwise add; overflow either wraps or clamps to all-ones.
    function automatic logic [WIDTH-1:0] f_pair_sum(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
`ifdef ADDER_SAT_EN
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        f_pair_sum = s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        f_pair_sum = x + y;
`endif
    endfunction

    // Ready flags are pure functions of slot state, forced low during reset.
    assign write_rdy1 = !r_a_full && !reset;
    assign write_rdy2 = !r_b_full && !reset;
    assign write_rdy3 = !reset;

    // The !ack guard stops a held write_en from re-capturing new data.
    assign w_cap1 = write_en1 && write_rdy1 && !r_ack1;
    assign w_cap2 = write_en2 && write_rdy2 && !r_ack2;
    assign w_cap3 = write_en3 && write_rdy3 && !r_ack3;

    assign w_fire = on_off && r_a_full && r_b_full && r_cfg_valid;

    // Lower half of the result reduces A, upper half reduces B.
    for (genvar k = 0; k < c_HALF; k++) begin : g_pair
        assign w_sum[k]          = f_pair_sum(r_a_data[2*k], r_a_data[2*k+1]);
        assign w_sum[k + c_HALF] = f_pair_sum(r_b_data[2*k], r_b_data[2*k+1]);
    end

    // Only the tag bits of the config word drive logic.
    assign w_unused_cfg = &{1'b0, r_cfg[WIDTH-1:c_DEST_W]};

    // Four-phase acknowledges: set on capture, cleared once write_en drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack1 <= 1'b0;
            r_ack2 <= 1'b0;
            r_ack3 <= 1'b0;
        end else begin
            if (w_cap1)          r_ack1 <= 1'b1;
            else if (!write_en1) r_ack1 <= 1'b0;
            if (w_cap2)          r_ack2 <= 1'b1;
            else if (!write_en2) r_ack2 <= 1'b0;
            if (w_cap3)          r_ack3 <= 1'b1;
            else if (!write_en3) r_ack3 <= 1'b0;
        end
    end

    // Operand slots: fill on capture, drain on fire (never both on one slot).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_data <= '0;
            r_b_data <= '0;
            r_a_full <= 1'b0;
            r_b_full <= 1'b0;
        end else begin
            if (w_cap1) begin
                r_a_data <= w_data_in1;
                r_a_full <= 1'b1;
            end else if (w_fire) begin
                r_a_full <= 1'b0;
            end
            if (w_cap2) begin
                r_b_data <= w_data_in2;
                r_b_full <= 1'b1;
            end else if (w_fire) begin
                r_b_full <= 1'b0;
            end
        end
    end

    // Config is always rewritable; a coincident fire still sees the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg       <= '0;
            r_cfg_valid <= 1'b0;
        end else if (w_cap3) begin
            r_cfg       <= w_data_in3;
            r_cfg_valid <= 1'b1;
        end
    end

    // Result registers load on fire and otherwise hold; strobe lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= '0;
            r_dest <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fire;
            if (w_fire) begin
                r_out  <= w_sum;
                r_dest <= r_cfg[c_DEST_W-1:0];
            end
        end
    end

    assign write_ack1    = r_ack1;
    assign write_ack2    = r_ack2;
    assign write_ack3    = r_ack3;
    assign adder_outputs = r_out;
    assign dest_info     = r_dest;
    assign adder_ack     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_v_tile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_v_tile
//  Brief    : Self-checking bench for v_tile. Expected result vectors and
//             tags are queued when operands are sent and compared when the
//             tile strobes adder_ack.
//  Revision : 1.0  initial release
// ============================================================================
module tb_v_tile;

    localparam int c_W = 16;
    localparam int c_N = 4;
    localparam int c_R = 16;

    typedef logic [c_N-1:0][c_W-1:0] vec_t;
    typedef struct {
        vec_t       v;
        logic [3:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       on_off;
    logic       write_en1, write_en2, write_en3;
    logic       write_rdy1, write_rdy2, write_rdy3;
    logic       write_ack1, write_ack2, write_ack3;
    vec_t       w_data_in1, w_data_in2;
    logic [c_W-1:0] w_data_in3;
    vec_t       adder_outputs;
    logic [3:0] dest_info;
    logic       adder_ack;

    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    logic prev_ack = 1'b0;
    exp_t sb[$];

    v_tile #(.WIDTH(c_W), .NUM_INPUTS(c_N), .NUM_REGS(c_R)) dut (
        .clk(clk), .reset(reset), .on_off(on_off),
        .write_en1(write_en1), .write_rdy1(write_rdy1), .w_data_in1(w_data_in1), .write_ack1(write_ack1),
        .write_en2(write_en2), .write_rdy2(write_rdy2), .w_data_in2(w_data_in2), .write_ack2(write_ack2),
        .write_en3(write_en3), .write_rdy3(write_rdy3), .w_data_in3(w_data_in3), .write_ack3(write_ack3),
        .adder_outputs(adder_outputs), .dest_info(dest_info), .adder_ack(adder_ack)
    );

    always #5 clk = ~clk;

    // Reference reduction: pairs of A feed the lower half, pairs of B the upper.
    function automatic vec_t model(input vec_t a, input vec_t b);
        vec_t r;
        logic [c_W:0] s;
        for (int k = 0; k < c_N; k++) begin
            if (k < c_N / 2) s = {1'b0, a[2*k]} + {1'b0, a[2*k+1]};
            else             s = {1'b0, b[2*(k-c_N/2)]} + {1'b0, b[2*(k-c_N/2)+1]};
`ifdef ADDER_SAT_EN
            if (s[c_W]) s = {1'b0, {c_W{1'b1}}};
`endif
            r[k] = s[c_W-1:0];
        end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int k = 0; k < c_N; k++) r[k] = c_W'($urandom);
        return r;
    endfunction

    // Scoreboard consumer: every strobe must match the oldest queued result.
    always @(negedge clk) begin
        if (adder_ack) begin
            pulses++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fire: adder_ack=1 outputs=%h, no result expected", adder_outputs);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (adder_outputs !== e.v || dest_info !== e.d) begin
                    errors++;
                    $display("FAIL result: got out=%h dest=%0d, want out=%h dest=%0d",
                             adder_outputs, dest_info, e.v, e.d);
                end
            end
            checks++;
            if (prev_ack) begin
                errors++;
                $display("FAIL ack_width: adder_ack high two cycles in a row, want one");
            end
        end
        prev_ack = adder_ack;
    end

    task automatic send_a(input vec_t v);
        int n;
        @(negedge clk);
        w_data_in1 = v;
        write_en1  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!write_ack1 && n < 20);
        checks++;
        if (write_ack1 !== 1'b1) begin
            errors++; $display("FAIL ack1_timeout: write_ack1=%b want 1", write_ack1);
        end
        write_en1 = 1'b0;
        @(negedge clk);
        checks++;
        if (write_ack1 !== 1'b0) begin
            errors++; $display("FAIL ack1_release: write_ack1=%b want 0", write_ack1);
        end
    endtask

    task automatic send_b(input vec_t v);
        int n;
        @(negedge clk);
        w_data_in2 = v;
        write_en2  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!write_ack2 && n < 20);
        checks++;
        if (write_ack2 !== 1'b1) begin
            errors++; $display("FAIL ack2_timeout: write_ack2=%b want 1", write_ack2);
        end
        write_en2 = 1'b0;
        @(negedge clk);
        checks++;
        if (write_ack2 !== 1'b0) begin
            errors++; $display("FAIL ack2_release: write_ack2=%b want 0", write_ack2);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL %s_drain: %0d results outstanding, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({write_rdy1, write_rdy2, write_rdy3} !== 3'b000) begin
            errors++; $display("FAIL rdy_in_reset: rdy=%b want 000", {write_rdy1, write_rdy2, write_rdy3});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({write_rdy1, write_rdy2, write_rdy3} !== 3'b111) begin
            errors++; $display("FAIL rdy_idle: rdy=%b want 111", {write_rdy1, write_rdy2, write_rdy3});
        end
        checks++;
        if ({write_ack1, write_ack2, write_ack3, adder_ack} !== 4'b0000) begin
            errors++; $display("FAIL ack_idle: acks=%b want 0000", {write_ack1, write_ack2, write_ack3, adder_ack});
        end
        checks++;
        if (adder_outputs !== '0 || dest_info !== 4'd0) begin
            errors++; $display("FAIL out_idle: out=%h dest=%0d want 0/0", adder_outputs, dest_info);
        end
    endtask

    task automatic test_config();
        @(negedge clk);
        w_data_in3 = 16'h0003;
        write_en3  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (write_ack3 !== 1'b1) begin
                errors++; $display("FAIL cfg_ack_hold: write_ack3=%b want 1", write_ack3);
            end
        end
        write_en3 = 1'b0;
        @(negedge clk);
        checks++;
        if (write_ack3 !== 1'b0 || write_rdy3 !== 1'b1) begin
            errors++; $display("FAIL cfg_ack_drop: ack3=%b rdy3=%b want 0/1", write_ack3, write_rdy3);
        end
    endtask

    task automatic test_basic();
        vec_t a, b;
        exp_t e;
        a = {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
        b = {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
`ifdef ADDER_SAT_EN
        e.v = {16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF};
`else
        e.v = {16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFE};
`endif
        e.d = 4'd3;
        fork
            send_a(a);
            send_b(b);
        join
        checks++;
        if (write_rdy1 !== 1'b0 || write_rdy2 !== 1'b0 || pulses != 0) begin
            errors++; $display("FAIL basic_loaded: rdy1=%b rdy2=%b pulses=%0d want 0/0/0", write_rdy1, write_rdy2, pulses);
        end
        sb.push_back(e);
        on_off = 1'b1;
        @(negedge clk);
        checks++;
        if (adder_ack !== 1'b1) begin
            errors++; $display("FAIL basic_latency: adder_ack=%b want 1 one clock after on_off", adder_ack);
        end
        @(negedge clk);
        checks++;
        if (adder_ack !== 1'b0 || write_rdy1 !== 1'b1 || write_rdy2 !== 1'b1) begin
            errors++; $display("FAIL basic_after: ack=%b rdy1=%b rdy2=%b want 0/1/1", adder_ack, write_rdy1, write_rdy2);
        end
        on_off = 1'b0;
        wait_drain("basic");
    endtask

    task automatic test_on_off_gate();
        vec_t a, b, held;
        exp_t e;
        int   p0;
        a = rand_vec();
        b = rand_vec();
        fork
            send_a(a);
            send_b(b);
        join
        held = adder_outputs;
        p0   = pulses;
        repeat (10) @(negedge clk);
        checks++;
        if (pulses != p0 || adder_outputs !== held || dest_info !== 4'd3) begin
            errors++; $display("FAIL gate_hold: pulses=%0d out=%h dest=%0d want %0d/%h/3", pulses, adder_outputs, dest_info, p0, held);
        end
        e.v = model(a, b);
        e.d = 4'd3;
        sb.push_back(e);
        on_off = 1'b1;
        @(negedge clk);
        checks++;
        if (adder_ack !== 1'b1) begin
            errors++; $display("FAIL gate_fire: adder_ack=%b want 1", adder_ack);
        end
        on_off = 1'b0;
        wait_drain("gate");
    endtask

    task automatic test_hold_en();
        vec_t x, y, z;
        exp_t e;
        x = rand_vec();
        y = ~x;
        z = rand_vec();
        @(negedge clk);
        w_data_in1 = x;
        write_en1  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            w_data_in1 = y;
            checks++;
            if (write_ack1 !== 1'b1 || write_rdy1 !== 1'b0) begin
                errors++; $display("FAIL hold_en: cycle %0d ack1=%b rdy1=%b want 1/0", i, write_ack1, write_rdy1);
            end
        end
        write_en1 = 1'b0;
        @(negedge clk);
        checks++;
        if (write_ack1 !== 1'b0 || write_rdy1 !== 1'b0) begin
            errors++; $display("FAIL hold_release: ack1=%b rdy1=%b want 0/0", write_ack1, write_rdy1);
        end
        send_b(z);
        e.v = model(x, z);
        e.d = 4'd3;
        sb.push_back(e);
        on_off = 1'b1;
        wait_drain("hold");
        on_off = 1'b0;
        @(negedge clk);
        checks++;
        if (write_rdy1 !== 1'b1) begin
            errors++; $display("FAIL hold_rdy_after: rdy1=%b want 1", write_rdy1);
        end
    endtask

    task automatic test_config_race();
        vec_t a, b;
        exp_t e;
        a = rand_vec();
        b = rand_vec();
        fork
            send_a(a);
            send_b(b);
        join
        e.v = model(a, b);
        e.d = 4'd3;
        sb.push_back(e);
        @(negedge clk);
        on_off     = 1'b1;
        w_data_in3 = 16'hABC5;
        write_en3  = 1'b1;
        @(negedge clk);
        write_en3 = 1'b0;
        on_off    = 1'b0;
        wait_drain("race_old");
        a = rand_vec();
        b = rand_vec();
        fork
            send_a(a);
            send_b(b);
        join
        e.v = model(a, b);
        e.d = 4'd5;
        sb.push_back(e);
        on_off = 1'b1;
        wait_drain("race_new");
        on_off = 1'b0;
    endtask

    task automatic test_back_to_back();
        vec_t a, b;
        exp_t e;
        on_off = 1'b1;
        for (int r = 0; r < 4; r++) begin
            a = rand_vec();
            b = rand_vec();
            if (r == 0) begin
                a = {16'h8000, 16'h8000, 16'hFFFF, 16'h0001};
                b = {16'h7FFF, 16'h0001, 16'h1234, 16'hFFFF};
            end
            e.v = model(a, b);
            e.d = 4'd5;
            sb.push_back(e);
            fork
                send_a(a);
                send_b(b);
            join
            wait_drain("b2b");
        end
        on_off = 1'b0;
    endtask

    task automatic test_reset_mid();
        int p0;
        send_a(rand_vec());
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (write_rdy1 !== 1'b1 || adder_outputs !== '0 || dest_info !== 4'd0) begin
            errors++; $display("FAIL reset_mid: rdy1=%b out=%h dest=%0d want 1/0/0", write_rdy1, adder_outputs, dest_info);
        end
        p0 = pulses;
        send_b(rand_vec());
        on_off = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (pulses != p0 || adder_ack !== 1'b0) begin
            errors++; $display("FAIL reset_no_fire: pulses=%0d want %0d", pulses, p0);
        end
        on_off = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        on_off     = 1'b0;
        write_en1  = 1'b0;
        write_en2  = 1'b0;
        write_en3  = 1'b0;
        w_data_in1 = '0;
        w_data_in2 = '0;
        w_data_in3 = '0;
        test_reset();
        test_config();
        test_basic();
        test_on_off_gate();
        test_hold_en();
        test_config_race();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/v_tile.md
Name: v_tile

Overview:
- Vector reduction tile for the CGRA fabric.
- Accepts two operand vectors and one configuration word over three independent ready/enable/ack write ports.
- When enabled by on_off, computes pairwise sums of adjacent elements across the concatenated operands.
- Presents the registered result vector, a destination tag taken from the config word, and a one-cycle completion strobe.

Parameters:
- width, 16, element and config word width in bits
- num_inputs, 4, elements per operand vector and per result vector; must be even and at least 2
- num_regs, 16, size of the downstream register space; dest_info is clog2(num_regs) bits wide (4 at default)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- on_off  in  1  compute enable (level)
- write_en1  in  1  operand-A write request
- write_rdy1  out  1  operand-A slot empty
- w_data_in1  in  num_inputs x width  operand-A vector
- write_ack1  out  1  operand-A accepted
- write_en2  in  1  operand-B write request
- write_rdy2  out  1  operand-B slot empty
- w_data_in2  in  num_inputs x width  operand-B vector
- write_ack2  out  1  operand-B accepted
- write_en3  in  1  config write request
- write_rdy3  out  1  config port ready
- w_data_in3  in  width  config word
- write_ack3  out  1  config accepted
- adder_outputs  out  num_inputs x width  result vector (registered)
- dest_info  out  clog2(num_regs)  destination tag (registered)
- adder_ack  out  1  result-valid strobe

Behaviour:
- Reset (synchronous): clears slot-full flags for A and B, config-valid, stored data, adder_outputs, dest_info, adder_ack and all write_ack.
- While reset is high, all write_rdy are 0.
- write_rdy1/2 = slot empty and not reset, combinational from state.
- write_rdy3 = 1 whenever not in reset; the config register is always rewritable.
- Capture condition per port: write_en & write_rdy & !write_ack on a rising edge.
  - Captured data is stored, the slot is marked full (config-valid for port 3), and write_ack goes high at that edge.
  - write_ack holds high while write_en stays high and clears on the first edge with write_en low (four-phase handshake).
  - The !write_ack guard prevents re-capture while the writer holds write_en.
- Ports 1 and 2 operate concurrently and independently, in either order or in the same cycle.
- Fire condition: on_off & A full & B full & config valid, sampled at a rising edge. At that edge:
  - For k < num_inputs/2: adder_outputs[k] = A[2k] + A[2k+1].
  - For k >= num_inputs/2, with j = k - num_inputs/2: adder_outputs[k] = B[2j] + B[2j+1].
  - Sums are truncated modulo 2^width (unsigned, carry discarded).
  - dest_info is loaded with config[clog2(num_regs)-1:0].
  - adder_ack = 1 for exactly one cycle.
  - A and B slots are cleared, so write_rdy1/2 return high next cycle. Config is retained.
- Latency: results are visible one clock after the first edge where the fire condition holds.
- on_off low: no fire. Operands stay buffered and outputs hold their last values.
- on_off held high: the tile fires again each time both slots refill.
- A write to port 1 or 2 cannot coincide with a fire on the same slot, because fire requires the slot to be full.
- A config write coinciding with a fire: the fire uses the old config; the new config applies to later fires.
- Reset asserted mid-handshake or mid-fire discards all pending data; outputs return to 0.

Optional Feature:
- Macro ADDER_SAT_EN.
- When defined: each pairwise sum saturates to 2^width-1 on unsigned overflow (e.g. FFFF+FFFF = FFFF).
- When undefined: wrap-around truncation (FFFF+FFFF = FFFE).
- Nothing else changes.

Test Plan:
- Reset, then idle -> write_rdy1/2/3 = 1, write_acks = 0, adder_outputs all 0, adder_ack = 0, dest_info = 0.
- Config 0x0003 written on port 3 -> write_ack3 high until write_en3 drops; after a fire, dest_info = 3.
- A = {FFFF,FFFF,0000,0000}, B = {FFFF,0000,FFFF,0000} (index 0 first) written in parallel, then on_off = 1 -> within 15 ns (about 1.5 clocks), outputs = {FFFE,0000,FFFF,FFFF}, adder_ack pulses once, write_rdy1/2 = 1 again. With ADDER_SAT_EN: out[0] = FFFF.
- Operands loaded with on_off = 0 for 10 cycles -> no adder_ack, outputs unchanged; raising on_off fires on the next edge.
- write_en1 held high for 5 cycles after ack -> only one capture; write_rdy1 stays 0 until the fire.
- Reset asserted after A loaded but before B -> write_rdy1 = 1 after reset; a later B-only load plus on_off does not fire.
